// File: rtl/dro_pkg.sv
// Shared constants and the per-channel state record for the destructive-readout bank.
package dro_pkg;

  localparam int GUARD_MAX  = 15;
  localparam int CNT_W      = 4;
  localparam int VIOL_CNT_W = 16;

  typedef struct packed {
    logic             stored;
    logic [CNT_W-1:0] since_set;
    logic [CNT_W-1:0] since_read;
    logic             flag;
  } cell_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/dro_cell.sv
// One destructive-readout channel: stored bit, registered readout pulse and
// set/read guard-window checking with a sticky violation flag.
module dro_cell
  import dro_pkg::*;
#(
  parameter int GUARD = 2,
  parameter int NDRO  = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic read,
  input  logic viol_clr,
  output logic out,
  output logic state,
  output logic viol,
  output logic new_viol
);

  localparam logic [CNT_W-1:0] GLIM  = CNT_W'(GUARD);
  localparam logic [CNT_W-1:0] LOAD  = (GUARD > 0) ? CNT_W'(1) : CNT_W'(0);
  localparam logic             CHECK = (GUARD > 0);
  localparam logic             DESTR = (NDRO == 0);

  cell_t cur, nxt;
  logic  out_r;
  logic  setup_v, hold_v;

  // Counters hold "edges since the last event", so the pre-edge value equals
  // the separation k; a simultaneous set counts as k = 0 for the setup check.
  always_comb begin
    nxt     = cur;
    setup_v = CHECK & read & (set | (cur.since_set < GLIM));
    hold_v  = CHECK & set & (cur.since_read < GLIM);
    nxt.since_set  = set  ? LOAD : sat_inc(cur.since_set, GLIM);
    nxt.since_read = read ? LOAD : sat_inc(cur.since_read, GLIM);
    if (set)
      nxt.stored = 1'b1;
    else if (read && DESTR)
      nxt.stored = 1'b0;
    nxt.flag = (cur.flag & ~viol_clr) | setup_v | hold_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= '{stored: 1'b0, since_set: GLIM, since_read: GLIM, flag: 1'b0};
      out_r <= 1'b0;
    end else begin
      cur   <= nxt;
      out_r <= read & cur.stored;
    end
  end

  assign out      = out_r;
  assign state    = cur.stored;
  assign viol     = cur.flag;
  assign new_viol = setup_v | hold_v;

endmodule

// File: rtl/dro_bank.sv
// Bank of independent DRO channels. Defining DRO_BANK_VIOL_CNT_EN adds a
// saturating count of cycles containing at least one new violation.
module dro_bank
  import dro_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int GUARD    = 2,
  parameter int NDRO     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   set_i,
  input  logic [CHANNELS-1:0]   read_i,
  input  logic                  viol_clr_i,
  output logic [CHANNELS-1:0]   out_o,
  output logic [CHANNELS-1:0]   state_o,
  output logic [CHANNELS-1:0]   viol_o
`ifdef DRO_BANK_VIOL_CNT_EN
  ,
  output logic [VIOL_CNT_W-1:0] viol_cnt_o
`endif
);

  logic [CHANNELS-1:0] new_viol;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_cell
    dro_cell #(.GUARD(GUARD), .NDRO(NDRO)) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .set      (set_i[c]),
      .read     (read_i[c]),
      .viol_clr (viol_clr_i),
      .out      (out_o[c]),
      .state    (state_o[c]),
      .viol     (viol_o[c]),
      .new_viol (new_viol[c])
    );
  end

`ifdef DRO_BANK_VIOL_CNT_EN
  logic [VIOL_CNT_W-1:0] viol_cnt;
  logic                  any_new;

  assign any_new = |new_viol;

  // A new violation on the clearing edge restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      viol_cnt <= '0;
    else if (any_new)
      viol_cnt <= viol_clr_i ? VIOL_CNT_W'(1)
                             : ((&viol_cnt) ? viol_cnt : viol_cnt + 1'b1);
    else if (viol_clr_i)
      viol_cnt <= '0;
  end

  assign viol_cnt_o = viol_cnt;
`endif

endmodule

// File: tb/tb_dro_bank.sv
// Scoreboard bench for dro_bank: two instances (NDRO=0 and NDRO=1) share stimulus
// and are checked against an event-time reference model.
module tb_dro_bank;

  localparam int CH = 4;
  localparam int G  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] set_i, read_i;
  logic          viol_clr_i;
  logic [CH-1:0] out0, state0, viol0, out1, state1, viol1;
  logic [15:0]   cnt0, cnt1;

  always #5 clk = ~clk;

`ifndef DRO_BANK_VIOL_CNT_EN
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

  dro_bank #(.CHANNELS(CH), .GUARD(G), .NDRO(0)) dut0 (
`ifdef DRO_BANK_VIOL_CNT_EN
    .viol_cnt_o(cnt0),
`endif
    .clk(clk), .rst_n(rst_n), .set_i(set_i), .read_i(read_i),
    .viol_clr_i(viol_clr_i), .out_o(out0), .state_o(state0), .viol_o(viol0)
  );

  dro_bank #(.CHANNELS(CH), .GUARD(G), .NDRO(1)) dut1 (
`ifdef DRO_BANK_VIOL_CNT_EN
    .viol_cnt_o(cnt1),
`endif
    .clk(clk), .rst_n(rst_n), .set_i(set_i), .read_i(read_i),
    .viol_clr_i(viol_clr_i), .out_o(out1), .state_o(state1), .viol_o(viol1)
  );

  typedef struct {
    logic [1:0][CH-1:0] out;
    logic [1:0][CH-1:0] state;
    logic [1:0][CH-1:0] viol;
    logic [15:0]        cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: absolute edge times of the last set/read per channel.
  int                 last_set [CH];
  int                 last_read[CH];
  logic [1:0][CH-1:0] m_state;
  logic [1:0][CH-1:0] m_viol;
  logic [15:0]        m_cnt;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < CH; c++) begin
      last_set[c]  = -1000;
      last_read[c] = -1000;
    end
    m_state = '0;
    m_viol  = '0;
    m_cnt   = '0;
  endtask

  task automatic applyStimulus(input logic [CH-1:0] s, input logic [CH-1:0] r, input logic c);
    exp_t e;
    logic anynew;
    logic newv;
    set_i      = s;
    read_i     = r;
    viol_clr_i = c;
    @(posedge clk);
    cyc++;
    anynew = 1'b0;
    for (int ch = 0; ch < CH; ch++) begin
      newv = (r[ch] && (s[ch] || (cyc - last_set[ch]) < G)) ||
             (s[ch] && (cyc - last_read[ch]) < G);
      anynew |= newv;
      for (int m = 0; m < 2; m++) begin
        e.out[m][ch] = r[ch] & m_state[m][ch];
        m_viol[m][ch] = (m_viol[m][ch] & ~c) | newv;
        if (s[ch])
          m_state[m][ch] = 1'b1;
        else if (r[ch] && m == 0)
          m_state[m][ch] = 1'b0;
      end
      if (s[ch]) last_set[ch] = cyc;
      if (r[ch]) last_read[ch] = cyc;
    end
    if (anynew)
      m_cnt = c ? 16'd1 : ((m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1);
    else if (c)
      m_cnt = '0;
    e.state = m_state;
    e.viol  = m_viol;
    e.cnt   = m_cnt;
    q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, 1'b0);
  endtask

  // Asserts reset while any pending pulse is still visible and checks that
  // everything drops without waiting for a clock edge.
  task automatic doReset(input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    set_i = '0; read_i = '0; viol_clr_i = 1'b0;
    #1;
    checkOutput({tag, "_out0"},   32'(out0),   32'd0);
    checkOutput({tag, "_state0"}, 32'(state0), 32'd0);
    checkOutput({tag, "_viol0"},  32'(viol0),  32'd0);
    checkOutput({tag, "_out1"},   32'(out1),   32'd0);
    checkOutput({tag, "_state1"}, 32'(state1), 32'd0);
`ifdef DRO_BANK_VIOL_CNT_EN
    checkOutput({tag, "_cnt"},    32'(cnt0),   32'd0);
`endif
    checkOutput({tag, "_qempty"}, 32'(q.size()), 32'd0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every out-of-reset cycle presents one response to compare.
  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      mon_e = q.pop_front();
      checkOutput("out_dro",    32'(out0),   32'(mon_e.out[0]));
      checkOutput("state_dro",  32'(state0), 32'(mon_e.state[0]));
      checkOutput("viol_dro",   32'(viol0),  32'(mon_e.viol[0]));
      checkOutput("out_ndro",   32'(out1),   32'(mon_e.out[1]));
      checkOutput("state_ndro", 32'(state1), 32'(mon_e.state[1]));
      checkOutput("viol_ndro",  32'(viol1),  32'(mon_e.viol[1]));
`ifdef DRO_BANK_VIOL_CNT_EN
      checkOutput("cnt_dro",    32'(cnt0),   32'(mon_e.cnt));
      checkOutput("cnt_ndro",   32'(cnt1),   32'(mon_e.cnt));
`endif
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    set_i = '0; read_i = '0; viol_clr_i = 1'b0;
    modelReset();
    doReset("rst_init");

    // Clean set then read, then set-then-read too close.
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    idle(9);
    applyStimulus(4'b0000, 4'b0001, 1'b0);
    idle(3);
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 4'b0010, 1'b0);
    idle(4);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    idle(3);

    // Read-then-set hold window: k=1 violates, k=2 does not.
    applyStimulus(4'b0000, 4'b0100, 1'b0);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    idle(3);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    idle(3);
    applyStimulus(4'b0000, 4'b0100, 1'b0);
    idle(1);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    idle(3);

    // Simultaneous set/read on an empty channel; clear racing a new violation.
    applyStimulus(4'b1000, 4'b1000, 1'b0);
    idle(2);
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 4'b0001, 1'b1);
    idle(2);
    applyStimulus(4'b0000, 4'b0000, 1'b1);

    // NDRO readout repeated five cycles apart.
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    idle(4);
    applyStimulus(4'b0000, 4'b0001, 1'b0);
    idle(4);
    applyStimulus(4'b0000, 4'b0001, 1'b0);
    idle(3);

    // Three violating cycles, then reset while a readout pulse is live.
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0010, 4'b0010, 1'b0);
    idle(1);
    applyStimulus(4'b0010, 4'b0010, 1'b0);
    idle(1);
    applyStimulus(4'b0010, 4'b0010, 1'b0);
    idle(3);
    applyStimulus(4'b0000, 4'b0010, 1'b0);
    doReset("rst_mid");
    applyStimulus(4'b0000, 4'b0010, 1'b0);
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    idle(2);

    // Randomized traffic, sparse enough to straddle the guard windows.
    for (int i = 0; i < 500; i++) begin
      logic [CH-1:0] s, r;
      for (int c = 0; c < CH; c++) begin
        s[c] = ($urandom_range(0, 3) == 0);
        r[c] = ($urandom_range(0, 3) == 0);
      end
      applyStimulus(s, r, $urandom_range(0, 15) == 0);
      if (i == 250) doReset("rst_rand");
    end
    idle(2);

    @(negedge clk);
    #1;
    checkOutput("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
